// File: rtl/traffic_timer_bank_if.sv
// Bundle of per-channel control strobes and status outputs for traffic_timer_bank.
// The phase sequencer drives through master; the timer bank sits on slave.
interface traffic_timer_bank_if #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned CNT_W = 5
);
  logic [N_CH-1:0]       i_start;
  logic [N_CH-1:0]       i_abort;
  logic [N_CH*CNT_W-1:0] i_duration;
  logic                  i_pause;
  logic [N_CH-1:0]       o_busy;
  logic [N_CH-1:0]       o_done;
  logic [N_CH*CNT_W-1:0] o_remaining;

  modport master (
    output i_start, i_abort, i_duration, i_pause,
    input  o_busy, o_done, o_remaining
  );

  modport slave (
    input  i_start, i_abort, i_duration, i_pause,
    output o_busy, o_done, o_remaining
  );
endinterface

// File: rtl/traffic_timer_bank.sv
// Bank of N_CH independent down-counting phase timers sharing one prescaled tick.
// Per channel, abort beats start and start beats tick; i_pause only blocks ticks.
module traffic_timer_bank #(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned TICK_DIV = 1
) (
  input logic                 i_clk,
  input logic                 i_reset,
  traffic_timer_bank_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  state_e              state_q [N_CH];
  state_e              state_d [N_CH];
  logic [CNT_W-1:0]    rem_q   [N_CH];
  logic [CNT_W-1:0]    rem_d   [N_CH];
  logic [N_CH-1:0]     done_q, done_d;
  logic [N_CH-1:0]     busy;
  logic [N_CH*CNT_W-1:0] rem_flat;

  // Prescaler is free-running and never resynchronised by a start.
  always_comb begin
    presc_d = presc_q;
    if (!bus.i_pause) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end
  end

  assign tick = (presc_q == PRESC_LAST) && !bus.i_pause;

  always_comb begin
    done_d = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      logic [CNT_W-1:0] dur;
      dur        = bus.i_duration[k*CNT_W +: CNT_W];
      state_d[k] = state_q[k];
      rem_d[k]   = rem_q[k];
      if (bus.i_abort[k]) begin
        state_d[k] = StIdle;
        rem_d[k]   = '0;
      end else if (bus.i_start[k]) begin
        if (dur == '0) begin
          // Zero duration expires immediately without ever showing busy.
          state_d[k] = StIdle;
          rem_d[k]   = '0;
          done_d[k]  = 1'b1;
        end else begin
          state_d[k] = StRun;
          rem_d[k]   = dur;
        end
      end else if (tick && (state_q[k] == StRun)) begin
        if (rem_q[k] > CNT_W'(1)) begin
          rem_d[k] = rem_q[k] - CNT_W'(1);
        end else begin
          state_d[k] = StIdle;
          rem_d[k]   = '0;
          done_d[k]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc_q <= '0;
      done_q  <= '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        state_q[k] <= StIdle;
        rem_q[k]   <= '0;
      end
    end else begin
      presc_q <= presc_d;
      done_q  <= done_d;
      for (int unsigned k = 0; k < N_CH; k++) begin
        state_q[k] <= state_d[k];
        rem_q[k]   <= rem_d[k];
      end
    end
  end

  always_comb begin
    busy     = '0;
    rem_flat = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      busy[k]                      = (state_q[k] == StRun);
      rem_flat[k*CNT_W +: CNT_W]   = rem_q[k];
    end
  end

  assign bus.o_busy      = busy;
  assign bus.o_done      = done_q;
  assign bus.o_remaining = rem_flat;

endmodule

// File: tb/tb_traffic_timer_bank.sv
// Directed bench for traffic_timer_bank: one instance with TICK_DIV=1, one with TICK_DIV=4.
module tb_traffic_timer_bank;

  logic i_clk;
  logic i_reset;
  int   errors;
  int   checks;

  traffic_timer_bank_if #(.N_CH(2), .CNT_W(5)) bus ();
  traffic_timer_bank_if #(.N_CH(2), .CNT_W(5)) bus4 ();

  traffic_timer_bank #(.N_CH(2), .CNT_W(5), .TICK_DIV(1)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  traffic_timer_bank #(.N_CH(2), .CNT_W(5), .TICK_DIV(4)) dut4 (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus4)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [4:0] rem_of(input int ch);
    return bus.o_remaining[ch*5 +: 5];
  endfunction

  // Drive a start for one edge on the TICK_DIV=1 instance.
  task automatic pulse_start(input logic [1:0] mask, input logic [4:0] d0, input logic [4:0] d1);
    bus.i_start    = mask;
    bus.i_duration = {d1, d0};
    step();
    bus.i_start    = '0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    step();
    step();
    checks++;
    if (bus.o_busy !== 2'b00 || bus.o_done !== 2'b00 || bus.o_remaining !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b rem=%h want 0/0/0",
               bus.o_busy, bus.o_done, bus.o_remaining);
    end
    i_reset = 1'b0;
    step();
    checks++;
    if (bus4.o_busy !== 2'b00 || bus4.o_done !== 2'b00 || bus4.o_remaining !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs_div4: got busy=%b done=%b rem=%h want 0/0/0",
               bus4.o_busy, bus4.o_done, bus4.o_remaining);
    end
  endtask

  task automatic test_single();
    pulse_start(2'b01, 5'd25, 5'd0);
    for (int k = 0; k < 25; k++) begin
      checks++;
      if (bus.o_busy !== 2'b01 || rem_of(0) !== 5'(25 - k) || bus.o_done !== 2'b00) begin
        errors++;
        $display("FAIL single_count k=%0d: got busy=%b rem0=%0d done=%b want busy=01 rem0=%0d done=00",
                 k, bus.o_busy, rem_of(0), bus.o_done, 25 - k);
      end
      step();
    end
    checks++;
    if (bus.o_busy !== 2'b00 || bus.o_done !== 2'b01 || rem_of(0) !== 5'd0) begin
      errors++;
      $display("FAIL single_expiry: got busy=%b done=%b rem0=%0d want 00/01/0",
               bus.o_busy, bus.o_done, rem_of(0));
    end
    step();
    checks++;
    if (bus.o_done !== 2'b00) begin
      errors++;
      $display("FAIL single_done_pulse: got done=%b want 00", bus.o_done);
    end
  endtask

  task automatic test_concurrent();
    pulse_start(2'b11, 5'd25, 5'd4);
    for (int k = 1; k <= 26; k++) begin
      step();
      checks++;
      if (bus.o_done[1] !== (k == 4) || bus.o_done[0] !== (k == 25)) begin
        errors++;
        $display("FAIL concurrent_done k=%0d: got done=%b want done1=%0d done0=%0d",
                 k, bus.o_done, k == 4, k == 25);
      end
    end
    // Restart ch1 two edges into a four-tick run.
    pulse_start(2'b10, 5'd0, 5'd4);
    step();
    checks++;
    if (bus.o_done[1] !== 1'b0 || rem_of(1) !== 5'd3) begin
      errors++;
      $display("FAIL restart_pre: got done1=%b rem1=%0d want 0/3", bus.o_done[1], rem_of(1));
    end
    pulse_start(2'b10, 5'd0, 5'd4);
    checks++;
    if (bus.o_done[1] !== 1'b0 || rem_of(1) !== 5'd4 || bus.o_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL restart_reload: got done1=%b rem1=%0d busy1=%b want 0/4/1",
               bus.o_done[1], rem_of(1), bus.o_busy[1]);
    end
    for (int k = 3; k <= 7; k++) begin
      step();
      checks++;
      if (bus.o_done[1] !== (k == 6)) begin
        errors++;
        $display("FAIL restart_done k=%0d: got done1=%b want %0d", k, bus.o_done[1], k == 6);
      end
    end
  endtask

  task automatic test_pause();
    int exp_rem;
    pulse_start(2'b01, 5'd10, 5'd0);
    exp_rem = 10;
    for (int k = 1; k <= 14; k++) begin
      bus.i_pause = (k >= 4 && k <= 6);
      if (!bus.i_pause && exp_rem > 0) exp_rem--;
      step();
      checks++;
      if (rem_of(0) !== 5'(exp_rem) || bus.o_done[0] !== (k == 13)) begin
        errors++;
        $display("FAIL pause_count k=%0d: got rem0=%0d done0=%b want rem0=%0d done0=%0d",
                 k, rem_of(0), bus.o_done[0], exp_rem, k == 13);
      end
    end
    bus.i_pause = 1'b0;
    bus.i_pause = 1'b1;
    pulse_start(2'b10, 5'd0, 5'd5);
    step();
    step();
    checks++;
    if (rem_of(1) !== 5'd5 || bus.o_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL pause_start_hold: got rem1=%0d busy1=%b want 5/1", rem_of(1), bus.o_busy[1]);
    end
    bus.i_pause = 1'b0;
    step();
    checks++;
    if (rem_of(1) !== 5'd4) begin
      errors++;
      $display("FAIL pause_release: got rem1=%0d want 4", rem_of(1));
    end
    bus.i_abort = 2'b10;
    step();
    bus.i_abort = 2'b00;
  endtask

  task automatic test_abort_collisions();
    pulse_start(2'b01, 5'd6, 5'd0);
    step();
    step();
    step();
    checks++;
    if (rem_of(0) !== 5'd3) begin
      errors++;
      $display("FAIL abort_pre: got rem0=%0d want 3", rem_of(0));
    end
    bus.i_abort = 2'b01;
    step();
    bus.i_abort = 2'b00;
    checks++;
    if (bus.o_busy[0] !== 1'b0 || rem_of(0) !== 5'd0 || bus.o_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear: got busy0=%b rem0=%0d done0=%b want 0/0/0",
               bus.o_busy[0], rem_of(0), bus.o_done[0]);
    end
    step();
    checks++;
    if (bus.o_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got done0=%b want 0", bus.o_done[0]);
    end
    // Abort and start on the same edge.
    bus.i_abort = 2'b01;
    pulse_start(2'b01, 5'd7, 5'd0);
    bus.i_abort = 2'b00;
    checks++;
    if (bus.o_busy[0] !== 1'b0 || rem_of(0) !== 5'd0 || bus.o_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_same_edge: got busy0=%b rem0=%0d done0=%b want 0/0/0",
               bus.o_busy[0], rem_of(0), bus.o_done[0]);
    end
    // Restart landing on the final tick edge.
    pulse_start(2'b01, 5'd3, 5'd0);
    step();
    step();
    pulse_start(2'b01, 5'd5, 5'd0);
    checks++;
    if (bus.o_busy[0] !== 1'b1 || rem_of(0) !== 5'd5 || bus.o_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_on_expiry: got busy0=%b rem0=%0d done0=%b want 1/5/0",
               bus.o_busy[0], rem_of(0), bus.o_done[0]);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (bus.o_done[0] !== (k == 5)) begin
        errors++;
        $display("FAIL expiry_reload_done k=%0d: got done0=%b want %0d", k, bus.o_done[0], k == 5);
      end
    end
  endtask

  task automatic test_edge_durations();
    pulse_start(2'b01, 5'd0, 5'd0);
    checks++;
    if (bus.o_busy[0] !== 1'b0 || bus.o_done[0] !== 1'b1 || rem_of(0) !== 5'd0) begin
      errors++;
      $display("FAIL zero_duration: got busy0=%b done0=%b rem0=%0d want 0/1/0",
               bus.o_busy[0], bus.o_done[0], rem_of(0));
    end
    step();
    checks++;
    if (bus.o_done[0] !== 1'b0 || bus.o_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL zero_duration_after: got done0=%b busy0=%b want 0/0",
               bus.o_done[0], bus.o_busy[0]);
    end
    pulse_start(2'b01, 5'd31, 5'd0);
    checks++;
    if (rem_of(0) !== 5'd31 || bus.o_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL max_load: got rem0=%0d busy0=%b want 31/1", rem_of(0), bus.o_busy[0]);
    end
    for (int k = 1; k <= 30; k++) step();
    checks++;
    if (rem_of(0) !== 5'd1 || bus.o_busy[0] !== 1'b1 || bus.o_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL max_last: got rem0=%0d busy0=%b done0=%b want 1/1/0",
               rem_of(0), bus.o_busy[0], bus.o_done[0]);
    end
    step();
    checks++;
    if (rem_of(0) !== 5'd0 || bus.o_busy[0] !== 1'b0 || bus.o_done[0] !== 1'b1) begin
      errors++;
      $display("FAIL max_expiry: got rem0=%0d busy0=%b done0=%b want 0/0/1",
               rem_of(0), bus.o_busy[0], bus.o_done[0]);
    end
    step();
    checks++;
    if (rem_of(0) !== 5'd0 || bus.o_busy[0] !== 1'b0 || bus.o_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL max_no_wrap: got rem0=%0d busy0=%b done0=%b want 0/0/0",
               rem_of(0), bus.o_busy[0], bus.o_done[0]);
    end
  endtask

  task automatic test_tick_div4();
    logic [4:0] prev;
    int busy_cnt;
    int last_change;
    int changes;
    bit saw_done;
    bus4.i_start    = 2'b01;
    bus4.i_duration = {5'd0, 5'd3};
    step();
    bus4.i_start    = 2'b00;
    busy_cnt    = 0;
    last_change = -1;
    changes     = 0;
    saw_done    = 0;
    prev        = bus4.o_remaining[4:0];
    checks++;
    if (prev !== 5'd3 || bus4.o_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL div4_load: got rem0=%0d busy0=%b want 3/1", prev, bus4.o_busy[0]);
    end
    if (bus4.o_busy[0] === 1'b1) busy_cnt++;
    for (int k = 1; k <= 20 && !saw_done; k++) begin
      step();
      if (bus4.o_busy[0] === 1'b1) busy_cnt++;
      if (bus4.o_done[0] === 1'b1) saw_done = 1;
      if (bus4.o_remaining[4:0] !== prev) begin
        changes++;
        checks++;
        if (prev - bus4.o_remaining[4:0] !== 5'd1) begin
          errors++;
          $display("FAIL div4_step k=%0d: got rem0=%0d want %0d",
                   k, bus4.o_remaining[4:0], prev - 5'd1);
        end
        if (last_change >= 0) begin
          checks++;
          if (k - last_change !== 4) begin
            errors++;
            $display("FAIL div4_spacing k=%0d: got gap=%0d want 4", k, k - last_change);
          end
        end
        last_change = k;
        prev = bus4.o_remaining[4:0];
      end
    end
    checks++;
    if (!saw_done || changes != 3 || busy_cnt < 9 || busy_cnt > 12) begin
      errors++;
      $display("FAIL div4_busy_len: got done_seen=%0d changes=%0d busy=%0d want 1/3/[9,12]",
               saw_done, changes, busy_cnt);
    end
  endtask

  task automatic test_async_reset();
    bus4.i_start    = 2'b11;
    bus4.i_duration = {5'd7, 5'd3};
    pulse_start(2'b11, 5'd20, 5'd9);
    bus4.i_start    = 2'b00;
    step();
    checks++;
    if (bus.o_busy !== 2'b11 || bus4.o_busy !== 2'b11) begin
      errors++;
      $display("FAIL async_pre: got busy=%b busy4=%b want 11/11", bus.o_busy, bus4.o_busy);
    end
    #3;
    i_reset = 1'b1;
    #1;
    checks++;
    if (bus.o_busy !== 2'b00 || bus.o_remaining !== 10'd0 || bus.o_done !== 2'b00 ||
        bus4.o_busy !== 2'b00 || bus4.o_remaining !== 10'd0) begin
      errors++;
      $display("FAIL async_clear: got busy=%b rem=%h done=%b busy4=%b rem4=%h want all 0",
               bus.o_busy, bus.o_remaining, bus.o_done, bus4.o_busy, bus4.o_remaining);
    end
    step();
    i_reset = 1'b0;
    step();
    step();
    checks++;
    if (bus.o_busy !== 2'b00 || bus.o_done !== 2'b00 || bus4.o_done !== 2'b00) begin
      errors++;
      $display("FAIL async_after: got busy=%b done=%b done4=%b want 00/00/00",
               bus.o_busy, bus.o_done, bus4.o_done);
    end
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    i_reset         = 1'b1;
    bus.i_start     = '0;
    bus.i_abort     = '0;
    bus.i_duration  = '0;
    bus.i_pause     = 1'b0;
    bus4.i_start    = '0;
    bus4.i_abort    = '0;
    bus4.i_duration = '0;
    bus4.i_pause    = 1'b0;
    test_reset();
    test_single();
    test_concurrent();
    test_pause();
    test_abort_collisions();
    test_edge_durations();
    test_tick_div4();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
